irq_plic_core: RTL

- Parametrised platform-level interrupt controller. Successor to the fixed four-IRQ interrupt controller.
- Takes NUM_SRC external sources. Each source has a level/edge gateway, a programmable priority, and per-context enables and thresholds.
- Each target context (e.g. M-mode and S-mode hart contexts) gets a registered interrupt line and a claim/complete handshake.
- Sits beside the CSR unit; irq_out feeds the MEIP/SEIP bits of mip.

---
 rtl/irq_plic_core_pkg.sv | 23 ++
 rtl/irq_plic_gateway.sv | 58 +++++
 rtl/irq_plic_core.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/irq_plic_core_pkg.sv
// rtl/irq_plic_core_pkg.sv - shared constants and width helpers for the PLIC core
//
// Purpose: the "no interrupt" ID, default sizing and helpers that derive
//          port widths from the sizing parameters.
// Ports:   none (package).
package irq_plic_core_pkg;

  localparam int PLIC_ID_NONE     = 0;
  localparam int PLIC_DEF_NUM_SRC = 31;
  localparam int PLIC_DEF_PRIO_W  = 3;
  localparam int PLIC_DEF_NUM_CTX = 2;

  // Width of a source ID; ID 0 is reserved, so NUM_SRC+1 codes are needed.
  function automatic int plic_id_w(input int num_src);
    return $clog2(num_src + 1);
  endfunction

  // Width of a context select; a single context still gets a 1-bit field.
  function automatic int plic_ctx_w(input int num_ctx);
    return (num_ctx > 1) ? $clog2(num_ctx) : 1;
  endfunction

endpackage

// File: rtl/irq_plic_gateway.sv
// rtl/irq_plic_gateway.sv - per-source level/edge gateway with pending and in-flight state
//
// Purpose: turns one raw interrupt line into a pending bit and tracks
//          whether the source is in flight between claim and complete.
// Ports:
//   clk, resetn  system clock, synchronous active-low reset
//   irq_src      raw source line (already synchronised)
//   edge_mode    1 = rising-edge triggered, 0 = level
//   claim        this source is being claimed this cycle
//   complete     a valid complete for this source arrives this cycle
//   pending      gateway pending bit
//   in_flight    source claimed and not yet completed
module irq_plic_gateway
  import irq_plic_core_pkg::*;
(
  input  logic clk,
  input  logic resetn,
  input  logic irq_src,
  input  logic edge_mode,
  input  logic claim,
  input  logic complete,
  output logic pending,
  output logic in_flight
);

  logic prev_q;
  logic rise;

  assign rise = irq_src & ~prev_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      pending   <= 1'b0;
      in_flight <= 1'b0;
      prev_q    <= 1'b0;
    end else begin
      prev_q <= irq_src;

      // Edge mode: an edge arriving in the claim cycle is a new event and
      // must not be lost, so it overrides the claim's clear.
      if (edge_mode) begin
        pending <= rise | (pending & ~claim);
      end else if (claim) begin
        pending <= 1'b0;
      end else if (!in_flight) begin
        pending <= irq_src;
      end

      // Claim beats a same-cycle complete so the source stays in flight.
      if (claim) begin
        in_flight <= 1'b1;
      end else if (complete) begin
        in_flight <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/irq_plic_core.sv
// rtl/irq_plic_core.sv - parametrised platform-level interrupt controller core
//
// Purpose: per-source gateways, programmable priorities, per-context enables
//          and thresholds, a registered max-priority arbiter per context and
//          the claim/complete handshake.
// Ports:
//   clk, resetn              system clock, synchronous active-low reset
//   irq_src, edge_mode       raw source lines and per-source trigger mode (bit 0 ignored)
//   prio_we/idx/wdata        priority register write
//   en_we/ctx/wdata          per-context enable mask write (bit 0 forced to 0)
//   thr_we/ctx/wdata         per-context threshold write
//   claim_req, claim_id      claim pulse per context and the ID returned in that cycle
//   complete_req/id          complete pulse and ID per context
//   irq_out                  registered interrupt request per context
//   pending_o                pending bits for read-back
module irq_plic_core
  import irq_plic_core_pkg::*;
#(
  parameter int NUM_SRC = PLIC_DEF_NUM_SRC,
  parameter int PRIO_W  = PLIC_DEF_PRIO_W,
  parameter int NUM_CTX = PLIC_DEF_NUM_CTX,
  parameter int ID_W    = plic_id_w(NUM_SRC),
  parameter int CTX_W   = plic_ctx_w(NUM_CTX)
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [NUM_SRC:0]        irq_src,
  input  logic [NUM_SRC:0]        edge_mode,
  input  logic                    prio_we,
  input  logic [ID_W-1:0]         prio_idx,
  input  logic [PRIO_W-1:0]       prio_wdata,
  input  logic                    en_we,
  input  logic [CTX_W-1:0]        en_ctx,
  input  logic [NUM_SRC:0]        en_wdata,
  input  logic                    thr_we,
  input  logic [CTX_W-1:0]        thr_ctx,
  input  logic [PRIO_W-1:0]       thr_wdata,
  input  logic [NUM_CTX-1:0]      claim_req,
  output logic [NUM_CTX*ID_W-1:0] claim_id,
  input  logic [NUM_CTX-1:0]      complete_req,
  input  logic [NUM_CTX*ID_W-1:0] complete_id,
  output logic [NUM_CTX-1:0]      irq_out,
  output logic [NUM_SRC:0]        pending_o
);

  logic [PRIO_W-1:0] prio_q  [NUM_SRC+1];
  logic [NUM_SRC:0]  en_q    [NUM_CTX];
  logic [PRIO_W-1:0] thr_q   [NUM_CTX];
  logic [ID_W-1:0]   best_id [NUM_CTX];

  logic [NUM_SRC:0] pending;
  logic [NUM_SRC:0] in_flight;
  logic [NUM_SRC:0] claim_hit;
  logic [NUM_SRC:0] complete_hit;

  // Bit 0 of the source-indexed vectors is the reserved "none" ID.
  logic unused_ok;
  assign unused_ok = ^{irq_src[0], edge_mode[0], en_wdata[0], in_flight,
                       claim_hit[0], complete_hit[0]};

  // ---------------------------------------------------------------- gateways
  assign pending[0]   = 1'b0;
  assign in_flight[0] = 1'b0;

  for (genvar i = 1; i <= NUM_SRC; i++) begin : g_gw
    irq_plic_gateway u_gw (
      .clk       (clk),
      .resetn    (resetn),
      .irq_src   (irq_src[i]),
      .edge_mode (edge_mode[i]),
      .claim     (claim_hit[i]),
      .complete  (complete_hit[i]),
      .pending   (pending[i]),
      .in_flight (in_flight[i])
    );
  end

  assign pending_o = pending;

  // ------------------------------------------------------- config registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i <= NUM_SRC; i++) begin
        prio_q[i] <= '0;
      end
      for (int c = 0; c < NUM_CTX; c++) begin
        en_q[c]  <= '0;
        thr_q[c] <= '0;
      end
    end else begin
      if (prio_we && (prio_idx != ID_W'(PLIC_ID_NONE)) && (int'(prio_idx) <= NUM_SRC)) begin
        prio_q[prio_idx] <= prio_wdata;
      end
      if (en_we && (int'(en_ctx) < NUM_CTX)) begin
        en_q[en_ctx] <= {en_wdata[NUM_SRC:1], 1'b0};
      end
      if (thr_we && (int'(thr_ctx) < NUM_CTX)) begin
        thr_q[thr_ctx] <= thr_wdata;
      end
    end
  end

  // ----------------------------------------------------- per-context arbiter
  for (genvar c = 0; c < NUM_CTX; c++) begin : g_arb
    logic [ID_W-1:0]   scan_id;
    logic [PRIO_W-1:0] scan_prio;
    logic [ID_W-1:0]   best_q;
    logic              irq_q;

    // Linear scan from ID 1 upwards; strict '>' keeps the lower ID on a tie.
    // scan_prio starts at 0, which any candidate beats since prio > thr >= 0.
    always_comb begin
      scan_id   = ID_W'(PLIC_ID_NONE);
      scan_prio = '0;
      for (int i = 1; i <= NUM_SRC; i++) begin
        if (pending[i] && en_q[c][i] && (prio_q[i] > thr_q[c]) && (prio_q[i] > scan_prio)) begin
          scan_id   = ID_W'(i);
          scan_prio = prio_q[i];
        end
      end
    end

    always_ff @(posedge clk) begin
      if (!resetn) begin
        best_q <= '0;
        irq_q  <= 1'b0;
      end else begin
        best_q <= scan_id;
        irq_q  <= (scan_id != ID_W'(PLIC_ID_NONE));
      end
    end

    assign best_id[c] = best_q;
    assign irq_out[c] = irq_q;
  end

  // ------------------------------------------------------------ claim path
  // best_id may be one cycle stale, so the grant re-checks pending. Contexts
  // are visited in ascending order so the lowest context wins a shared ID.
  always_comb begin
    claim_id  = '0;
    claim_hit = '0;
    for (int c = 0; c < NUM_CTX; c++) begin
      if (claim_req[c] && (best_id[c] != ID_W'(PLIC_ID_NONE)) &&
          pending[best_id[c]] && !claim_hit[best_id[c]]) begin
        claim_id[c*ID_W +: ID_W] = best_id[c];
        claim_hit[best_id[c]]    = 1'b1;
      end
    end
  end

  // --------------------------------------------------------- complete path
  // IDs 0 and > NUM_SRC never match; the gateway ignores completes of
  // sources that are not in flight.
  always_comb begin
    complete_hit = '0;
    for (int c = 0; c < NUM_CTX; c++) begin
      for (int i = 1; i <= NUM_SRC; i++) begin
        if (complete_req[c] && (complete_id[c*ID_W +: ID_W] == ID_W'(i))) begin
          complete_hit[i] = 1'b1;
        end
      end
    end
  end

endmodule
